dram_req_responder: RTL and testbench

DRAM_REQ_RESPONDER -- requirements
Module: dram_req_responder

---
 rtl/dram_resp_pkg.sv | 22 ++
 rtl/dram_resp_mem.sv | 36 +++
 rtl/dram_req_responder.sv | 147 ++++++++++++++
 tb/tb_dram_req_responder.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_resp_pkg.sv
// Shared FSM state encoding, default parameters and address helpers for dram_req_responder.
// The optional bounds check is enabled by defining DRAM_RESP_BOUNDS_CHECK_EN.
package dram_resp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACK   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_BURST = 2'd3
    } state_t;

    localparam int          DEF_DATA_W     = 16;
    localparam int          DEF_MEM_ADDR_W = 12;
    localparam logic [31:0] DEF_BASE_ADDR  = 32'h0000_0000;
    localparam int          DEF_LATENCY    = 4;

    // One-past-the-end store offset of a burst, kept at 33 bits so it cannot overflow.
    function automatic logic [32:0] span_end(input logic [31:0] off, input logic [15:0] len);
        return {1'b0, off} + {17'd0, len};
    endfunction

endpackage

// File: rtl/dram_resp_mem.sv
// Backing store: one write port (backdoor) and one synchronous read port, read-before-write.
module dram_resp_mem
    import dram_resp_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_MEM_ADDR_W
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_r [0:(1 << ADDR_W)-1];
    logic [DATA_W-1:0] rd_data_r;

    // Backdoor write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Synchronous read; a same-cycle write to this index is seen only on the next read.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data_r <= mem_r[rd_addr];
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/dram_req_responder.sv
// DRAM-style request responder: ack, fixed latency, then a gap-free burst read from a local store.
// Define DRAM_RESP_BOUNDS_CHECK_EN to zero out-of-range bursts and raise a sticky err.
module dram_req_responder
    import dram_resp_pkg::*;
#(
    parameter int          DATA_W     = DEF_DATA_W,
    parameter int          MEM_ADDR_W = DEF_MEM_ADDR_W,
    parameter logic [31:0] BASE_ADDR  = DEF_BASE_ADDR,
    parameter int          LATENCY    = DEF_LATENCY
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  dram_req,
    input  logic [31:0]           dram_addr,
    input  logic [15:0]           dram_len,
    output logic                  dram_ack,
    output logic                  dram_data_valid,
    output logic [DATA_W-1:0]     dram_data_out,
    input  logic                  load_en,
    input  logic [MEM_ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0]     load_data,
    output logic                  busy,
    output logic                  err
);

    localparam logic LAT_ONE = (LATENCY == 1);

    state_t                state_r;
    state_t                next_state_s;
    logic [MEM_ADDR_W-1:0] idx_r;
    logic [15:0]           rem_r;
    logic [7:0]            lat_cnt_r;
    logic                  bad_r;
    logic                  err_r;
    logic                  accept_s;
    logic                  rd_en_s;
    logic                  bad_s;
    logic [DATA_W-1:0]     rd_data_s;

    assign accept_s = (state_r == ST_IDLE) && dram_req;
    assign rd_en_s  = (next_state_s == ST_BURST);

`ifdef DRAM_RESP_BOUNDS_CHECK_EN
    localparam logic [32:0] DEPTH_33 = 33'd1 << MEM_ADDR_W;
    logic [31:0] off_s;
    assign off_s = dram_addr - BASE_ADDR;
    assign bad_s = (dram_addr < BASE_ADDR) || (span_end(off_s, dram_len) > DEPTH_33);
`else
    assign bad_s = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; WAIT is skipped entirely when LATENCY is 1.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (dram_req) next_state_s = ST_ACK;
                else          next_state_s = ST_IDLE;
            end
            ST_ACK: begin
                if (rem_r == 16'd0) next_state_s = ST_IDLE;
                else if (LAT_ONE)   next_state_s = ST_BURST;
                else                next_state_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (lat_cnt_r <= 8'd1) next_state_s = ST_BURST;
                else                   next_state_s = ST_WAIT;
            end
            ST_BURST: begin
                if (rem_r <= 16'd1) next_state_s = ST_IDLE;
                else                next_state_s = ST_BURST;
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Request capture, latency and beat counters, read pointer and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r     <= '0;
            rem_r     <= 16'd0;
            lat_cnt_r <= 8'd0;
            bad_r     <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            err_r <= err_r | (accept_s & bad_s);
            if (accept_s) begin
                idx_r <= MEM_ADDR_W'(dram_addr - BASE_ADDR);
                rem_r <= dram_len;
                bad_r <= bad_s;
            end else if (rd_en_s) begin
                idx_r <= idx_r + MEM_ADDR_W'(1);
            end
            if (state_r == ST_BURST) begin
                rem_r <= rem_r - 16'd1;
            end
            if ((state_r == ST_ACK) && (next_state_s == ST_WAIT)) begin
                lat_cnt_r <= 8'(LATENCY - 1);
            end else if (state_r == ST_WAIT) begin
                lat_cnt_r <= lat_cnt_r - 8'd1;
            end
        end
    end

    dram_resp_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (MEM_ADDR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (load_en),
        .wr_addr (load_addr),
        .wr_data (load_data),
        .rd_en   (rd_en_s),
        .rd_addr (idx_r),
        .rd_data (rd_data_s)
    );

    // Output decode; data is forced to zero outside beats and for rejected bursts.
    always_comb begin
        dram_ack        = 1'b0;
        dram_data_valid = 1'b0;
        dram_data_out   = '0;
        busy            = 1'b1;
        case (state_r)
            ST_IDLE:  busy = 1'b0;
            ST_ACK:   dram_ack = 1'b1;
            ST_WAIT:  busy = 1'b1;
            ST_BURST: begin
                dram_data_valid = 1'b1;
                if (bad_r) dram_data_out = '0;
                else       dram_data_out = rd_data_s;
            end
            default:  busy = 1'b0;
        endcase
        err = err_r;
    end

endmodule

// File: tb/tb_dram_req_responder.sv
// Self-checking bench for dram_req_responder: cycle-schedule model plus directed literal checks.
// Works with or without DRAM_RESP_BOUNDS_CHECK_EN defined.
module tb_dram_req_responder;

    localparam int          DATA_W     = 16;
    localparam int          MEM_ADDR_W = 12;
    localparam int          DEPTH      = 4096;
    localparam int          LATENCY    = 4;
    localparam logic [31:0] BASE_ADDR  = 32'h0;
    localparam int          NCYC       = 2048;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  dram_req = 1'b0;
    logic [31:0]           dram_addr = 32'd0;
    logic [15:0]           dram_len = 16'd0;
    logic                  dram_ack;
    logic                  dram_data_valid;
    logic [DATA_W-1:0]     dram_data_out;
    logic                  load_en = 1'b0;
    logic [MEM_ADDR_W-1:0] load_addr = '0;
    logic [DATA_W-1:0]     load_data = '0;
    logic                  busy;
    logic                  err;

    always #5 clk = ~clk;

    dram_req_responder #(
        .DATA_W     (DATA_W),
        .MEM_ADDR_W (MEM_ADDR_W),
        .BASE_ADDR  (BASE_ADDR),
        .LATENCY    (LATENCY)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .dram_req        (dram_req),
        .dram_addr       (dram_addr),
        .dram_len        (dram_len),
        .dram_ack        (dram_ack),
        .dram_data_valid (dram_data_valid),
        .dram_data_out   (dram_data_out),
        .load_en         (load_en),
        .load_addr       (load_addr),
        .load_data       (load_data),
        .busy            (busy),
        .err             (err)
    );

    int n_checks = 0;
    int n_err    = 0;

    bit [15:0] model_mem [0:DEPTH-1];
    bit        exp_ack   [0:NCYC-1];
    bit        exp_busy  [0:NCYC-1];
    bit        exp_valid [0:NCYC-1];
    bit [15:0] exp_data  [0:NCYC-1];
    int        free_at = 0;
    bit        err_m = 1'b0;

    int          ack_q[$];
    int          beat_q[$];
    logic [15:0] data_q[$];

    // Cycle c runs from the posedge at 10c-5 to the posedge at 10c+5.
    function automatic int cyc_now();
        return int'($time / 64'd10);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc_now(), act, exp);
        end
    endtask

    // Fill the expected-output timeline for a request accepted at the end of cycle t.
    task automatic schedule(input int t);
        logic [31:0] off;
        bit          bad;
        int          b;
        off = dram_addr - BASE_ADDR;
`ifdef DRAM_RESP_BOUNDS_CHECK_EN
        bad = (dram_addr < BASE_ADDR) || ((longint'(off) + longint'(dram_len)) > longint'(DEPTH));
`else
        bad = 1'b0;
`endif
        if (bad) err_m = 1'b1;
        if (t + 1 < NCYC) begin
            exp_ack[t+1]  = 1'b1;
            exp_busy[t+1] = 1'b1;
        end
        for (int k = 1; k <= LATENCY + int'(dram_len) - 1; k++) begin
            if (dram_len != 16'd0 && t + 1 + k < NCYC) exp_busy[t+1+k] = 1'b1;
        end
        for (int k = 0; k < int'(dram_len); k++) begin
            b = t + 1 + LATENCY + k;
            if (b < NCYC) begin
                exp_valid[b] = 1'b1;
                exp_data[b]  = bad ? 16'h0000 : model_mem[int'((off + 32'(k)) & 32'(DEPTH - 1))];
            end
        end
        free_at = (dram_len == 16'd0) ? t + 2 : t + LATENCY + int'(dram_len) + 1;
    endtask

    // Behavioural model: store shadow, acceptance decision, reset wipes the future timeline.
    always @(posedge clk or negedge rst_n) begin
        int c;
        c = cyc_now();
        if (!rst_n) begin
            for (int i = c; i < NCYC; i++) begin
                exp_ack[i]   = 1'b0;
                exp_busy[i]  = 1'b0;
                exp_valid[i] = 1'b0;
                exp_data[i]  = 16'h0000;
            end
            free_at = 0;
            err_m   = 1'b0;
        end else begin
            if (load_en) model_mem[load_addr] = load_data;
            if (dram_req && c >= free_at) schedule(c);
        end
    end

    // Compare every output against the model each cycle, and log acks and beats.
    always @(negedge clk) begin
        int c;
        c = cyc_now();
        if (rst_n && c < NCYC) begin
            check("ack",   32'(dram_ack),        32'(exp_ack[c]));
            check("busy",  32'(busy),            32'(exp_busy[c]));
            check("valid", 32'(dram_data_valid), 32'(exp_valid[c]));
            check("data",  32'(dram_data_out),   32'(exp_data[c]));
            check("err",   32'(err),             32'(err_m));
            if (dram_ack) ack_q.push_back(c);
            if (dram_data_valid) begin
                beat_q.push_back(c);
                data_q.push_back(dram_data_out);
            end
        end
    end

    task automatic load(input int a, input logic [15:0] d);
        @(negedge clk);
        load_en   = 1'b1;
        load_addr = MEM_ADDR_W'(a);
        load_data = d;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic clear_logs();
        ack_q.delete();
        beat_q.delete();
        data_q.delete();
    endtask

    task automatic do_req(input logic [31:0] a, input logic [15:0] l, output int t);
        clear_logs();
        @(negedge clk);
        dram_req  = 1'b1;
        dram_addr = a;
        dram_len  = l;
        t = cyc_now();
        @(negedge clk);
        dram_req  = 1'b0;
        dram_addr = 32'hDEAD_BEEF;
        dram_len  = 16'hFFFF;
    endtask

    task automatic wait_idle(output int c);
        int n;
        n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(busy), 32'd0);
        c = cyc_now();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        int c;
        logic [15:0] exp4 [0:3];

        #7;
        check("rst_ack",   32'(dram_ack),        32'd0);
        check("rst_valid", 32'(dram_data_valid), 32'd0);
        check("rst_data",  32'(dram_data_out),   32'd0);
        check("rst_busy",  32'(busy),            32'd0);
        check("rst_err",   32'(err),             32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) load(i, 16'h0100 + 16'(i));
        load(4094, 16'hAAAA);
        load(4095, 16'hBBBB);

        // Basic burst: addr 2, len 3.
        do_req(32'd2, 16'd3, t);
        wait_idle(c);
        check("b1_idle_cycle", 32'(c), 32'(t + 8));
        check("b1_nacks", 32'(ack_q.size()), 32'd1);
        check("b1_nbeats", 32'(beat_q.size()), 32'd3);
        if (ack_q.size() == 1) check("b1_ack_cycle", 32'(ack_q[0]), 32'(t + 1));
        if (beat_q.size() == 3) begin
            check("b1_first_beat", 32'(beat_q[0]), 32'(t + 5));
            check("b1_last_beat",  32'(beat_q[2]), 32'(t + 7));
            check("b1_d0", 32'(data_q[0]), 32'h0102);
            check("b1_d1", 32'(data_q[1]), 32'h0103);
            check("b1_d2", 32'(data_q[2]), 32'h0104);
        end

        // Zero-length request.
        do_req(32'd5, 16'd0, t);
        wait_idle(c);
        check("z_idle_cycle", 32'(c), 32'(t + 2));
        check("z_nacks", 32'(ack_q.size()), 32'd1);
        check("z_nbeats", 32'(beat_q.size()), 32'd0);

        // Burst across the top of the store.
        do_req(32'd4094, 16'd4, t);
        wait_idle(c);
`ifdef DRAM_RESP_BOUNDS_CHECK_EN
        exp4[0] = 16'h0000; exp4[1] = 16'h0000; exp4[2] = 16'h0000; exp4[3] = 16'h0000;
        check("w_err", 32'(err), 32'd1);
`else
        exp4[0] = 16'hAAAA; exp4[1] = 16'hBBBB; exp4[2] = 16'h0100; exp4[3] = 16'h0101;
        check("w_err", 32'(err), 32'd0);
`endif
        check("w_nacks", 32'(ack_q.size()), 32'd1);
        check("w_nbeats", 32'(data_q.size()), 32'd4);
        if (data_q.size() == 4) begin
            for (int k = 0; k < 4; k++) check("w_data", 32'(data_q[k]), 32'(exp4[k]));
        end

        // Reset during the second beat of an 8-beat burst.
        do_req(32'd8, 16'd8, t);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
        check("r_beat2_valid", 32'(dram_data_valid), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("r_valid", 32'(dram_data_valid), 32'd0);
        check("r_ack",   32'(dram_ack),        32'd0);
        check("r_busy",  32'(busy),            32'd0);
        check("r_data",  32'(dram_data_out),   32'd0);
        check("r_err",   32'(err),             32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        do_req(32'd2, 16'd3, t);
        wait_idle(c);
        check("r2_nbeats", 32'(data_q.size()), 32'd3);
        if (data_q.size() == 3) begin
            check("r2_d0", 32'(data_q[0]), 32'h0102);
            check("r2_d2", 32'(data_q[2]), 32'h0104);
        end

        // Request held high across back-to-back bursts.
        clear_logs();
        @(negedge clk);
        dram_req  = 1'b1;
        dram_addr = 32'd0;
        dram_len  = 16'd2;
        c = 0;
        while (ack_q.size() < 2 && c < 60) begin
            @(negedge clk);
            c++;
        end
        dram_req = 1'b0;
        check("h_two_acks", 32'(ack_q.size() >= 2), 32'd1);
        wait_idle(c);
        if (ack_q.size() >= 2 && beat_q.size() >= 2) begin
            check("h_ack_gap", 32'(ack_q[1] - beat_q[1]), 32'd2);
            check("h_d0", 32'(data_q[0]), 32'h0100);
            check("h_d1", 32'(data_q[1]), 32'h0101);
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
